// File: rtl/nibble_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: nibble width,
// sequencer state encoding and the nibble-count helper.
package nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of adder passes needed for an operand of the given width.
  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Operand/result handshake bundle for nibble_add_sequencer.
// The op port only exists when SUBTRACT_EN is defined.
interface nibble_add_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SUBTRACT_EN
  logic             op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
`ifdef SUBTRACT_EN
    output op,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
`ifdef SUBTRACT_EN
    input  op,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/nibble_add_sequencer_slice.sv
// Combinational 4-bit ripple-carry adder slice made of per-bit full adders.
module nibble_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]       = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i + 1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign co = w_c[4];

endmodule

// File: rtl/nibble_add_sequencer.sv
// Nibble-serial adder: one operation adds a + b + cin through a single shared
// 4-bit slice, LS nibble first, carry held in a register between passes.
// Optional macro SUBTRACT_EN adds an op input selecting a - b.
module nibble_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  nibble_add_sequencer_if.slave bus
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_sum, w_sum_nxt;
  logic             r_carry, w_carry_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_cout, w_cout_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             r_busy, w_busy_nxt;
`ifdef SUBTRACT_EN
  logic             r_op, w_op_nxt;
`endif

  logic [3:0]       w_y;
  logic [3:0]       w_s;
  logic             w_co;

  // Subtraction feeds the inverted B nibble; the carry register supplies the +1.
`ifdef SUBTRACT_EN
  assign w_y = r_op ? ~r_b[3:0] : r_b[3:0];
`else
  assign w_y = r_b[3:0];
`endif

  nibble_slice u_slice (
    .x  (r_a[3:0]),
    .y  (w_y),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode; every register holds by default.
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_sum_nxt       = r_sum;
    w_carry_nxt     = r_carry;
    w_idx_nxt       = r_idx;
    w_cout_nxt      = r_cout;
    w_out_valid_nxt = r_out_valid;
    w_in_ready_nxt  = r_in_ready;
    w_busy_nxt      = r_busy;
`ifdef SUBTRACT_EN
    w_op_nxt        = r_op;
`endif
    case (r_state)
      IDLE: begin
        if (r_in_ready && bus.in_valid) begin
          w_a_nxt        = bus.a;
          w_b_nxt        = bus.b;
          w_idx_nxt      = '0;
          w_in_ready_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = RUN;
`ifdef SUBTRACT_EN
          w_op_nxt       = bus.op;
          w_carry_nxt    = bus.op ? 1'b1 : bus.cin;
`else
          w_carry_nxt    = bus.cin;
`endif
        end else begin
          w_in_ready_nxt = 1'b1;
          w_busy_nxt     = 1'b0;
        end
      end
      RUN: begin
        w_a_nxt     = r_a >> NIBBLE_W;
        w_b_nxt     = r_b >> NIBBLE_W;
        w_carry_nxt = w_co;
        w_idx_nxt   = r_idx + IDX_W'(1);
        for (int i = 0; i < NIBBLES; i++) begin
          if (r_idx == IDX_W'(i)) begin
            w_sum_nxt[i*NIBBLE_W +: NIBBLE_W] = w_s;
          end else begin
            w_sum_nxt[i*NIBBLE_W +: NIBBLE_W] = r_sum[i*NIBBLE_W +: NIBBLE_W];
          end
        end
        if (r_idx == LAST_IDX) begin
          w_cout_nxt      = w_co;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end else begin
          w_state_nxt     = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = IDLE;
        end else begin
          w_state_nxt     = DONE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        w_busy_nxt      = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
`ifdef SUBTRACT_EN
      r_op        <= 1'b0;
`endif
    end else begin
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_sum       <= w_sum_nxt;
      r_carry     <= w_carry_nxt;
      r_idx       <= w_idx_nxt;
      r_cout      <= w_cout_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
`ifdef SUBTRACT_EN
      r_op        <= w_op_nxt;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.busy      = r_busy;

endmodule
